// File: rtl/shift_loop_ctrl_if.sv
// Handshake bundle between a requester and shift_loop_ctrl: word request in, recaptured word out.
// The requester uses the master modport, the controller the slave modport.
interface shift_loop_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             mismatch;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, mismatch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, mismatch
    );
endinterface

// File: rtl/shift_loop_ctrl.sv
// Serializes a word through an external DEPTH-stage shift register and recaptures it for loopback checking.
// Optional macro SHIFT_LOOP_LSB_FIRST_EN selects LSB-first serialization (default MSB first).
module shift_loop_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_loop_ctrl_if.slave  bus,
    output logic              sr_din,
    input  logic              sr_dout
);
    localparam int CNT_W = $clog2(WIDTH + DEPTH);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WIDTH + DEPTH - 1);
    localparam logic [WIDTH-1:0] LSB_MASK = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] capture_next;
    logic [WIDTH-1:0] out_data_r;
    logic             mismatch_r;
    logic             tx_bit;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        tx_bit       = 1'b0;
        capture_next = capture;
`ifdef SHIFT_LOOP_LSB_FIRST_EN
        tx_bit       = |(word & (LSB_MASK << cnt));
        capture_next = (capture >> 1) | (WIDTH'(sr_dout) << (WIDTH - 1));
`else
        tx_bit       = |(word & (MSB_MASK >> cnt));
        capture_next = (capture << 1) | WIDTH'(sr_dout);
`endif
        sr_din = 1'b0;
        if (state == S_BUSY && cnt < WIDTH_C) begin
            sr_din = tx_bit;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            word       <= '0;
            capture    <= '0;
            out_data_r <= '0;
            mismatch_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        word  <= bus.in_data;
                        cnt   <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Bits leaving the register before cnt reaches DEPTH are stale and skipped.
                    if (cnt >= DEPTH_C) begin
                        capture <= capture_next;
                    end
                    if (cnt == LAST_C) begin
                        state      <= S_DONE;
                        cnt        <= '0;
                        out_data_r <= capture_next;
                        mismatch_r <= (capture_next != word);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // in_ready is gated by rst_n so it stays low while reset is asserted even though state is IDLE.
    assign bus.in_ready  = rst_n && (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.out_data  = out_data_r;
    assign bus.mismatch  = mismatch_r;
endmodule

// File: tb/tb_shift_loop_ctrl.sv
// Directed bench for shift_loop_ctrl with a behavioural 4-stage shift register in the loop.
// Build with SHIFT_LOOP_LSB_FIRST_EN defined to exercise LSB-first ordering.
module tb_shift_loop_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sr_din;
    logic sr_dout;
    logic break_loop = 1'b0;
    logic [DEPTH-1:0] sr = '1;

    int checks = 0;
    int failures = 0;

    shift_loop_ctrl_if #(.WIDTH(WIDTH)) bus ();

    shift_loop_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .sr_din  (sr_din),
        .sr_dout (sr_dout)
    );

    always #5 clk = ~clk;

    // Attached shift register: no reset, no enable.
    always @(posedge clk) sr <= {sr[DEPTH-2:0], sr_din};
    assign sr_dout = break_loop ? 1'b0 : sr[DEPTH-1];

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic tx_model(input logic [7:0] d, input int k);
`ifdef SHIFT_LOOP_LSB_FIRST_EN
        return d[k];
`else
        return d[7-k];
`endif
    endfunction

    task automatic accept(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (sr_din !== 1'b0) begin failures++; $display("FAIL reset_sr_din got=%b exp=0", sr_din); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        checks++; if (bus.mismatch !== 1'b0) begin failures++; $display("FAIL reset_mismatch got=%b exp=0", bus.mismatch); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_idle_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        bit ok;
        logic exp_bit;
        bus.out_ready = 1'b1;
        accept(8'hA5, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_accept got=%b exp=1", ok); end
        // Acceptance edge already taken; 12 more edges make the 13th edge raise out_valid.
        for (int k = 0; k < WIDTH + DEPTH; k++) begin
            exp_bit = (k < WIDTH) ? tx_model(8'hA5, k) : 1'b0;
            checks++; if (sr_din !== exp_bit) begin failures++; $display("FAIL basic_sr_din cyc=%0d got=%b exp=%b", k, sr_din, exp_bit); end
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL basic_busy cyc=%0d out_valid=%b in_ready=%b exp=0,0", k, bus.out_valid, bus.in_ready); end
            tick();
        end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency out_valid=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", bus.out_data); end
        checks++; if (bus.mismatch !== 1'b0) begin failures++; $display("FAIL basic_mismatch got=%b exp=0", bus.mismatch); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_release out_valid=%b in_ready=%b exp=0,1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.out_data !== 8'hA5) begin failures++; $display("FAIL basic_hold got=%h exp=a5", bus.out_data); end
    endtask

    task automatic test_stall();
        bit ok;
        int n;
        bus.out_ready = 1'b0;
        accept(8'hA5, ok);
        wait_valid(n);
        checks++; if (n !== 12) begin failures++; $display("FAIL stall_latency got=%0d exp=12", n); end
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h3C;
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_hold cyc=%0d out_valid=%b in_ready=%b exp=1,0", k, bus.out_valid, bus.in_ready); end
            checks++; if (bus.out_data !== 8'hA5 || bus.mismatch !== 1'b0) begin failures++; $display("FAIL stall_data cyc=%0d got=%h/%b exp=a5/0", k, bus.out_data, bus.mismatch); end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL stall_release out_valid=%b in_ready=%b exp=0,1", bus.out_valid, bus.in_ready); end
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stall_no_queue in_ready=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h01;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_start_ready got=%b exp=1", bus.in_ready); end
        tick();
        bus.in_data = 8'hFE;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n !== 12) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=12", n); end
        checks++; if (bus.out_data !== 8'h01 || bus.mismatch !== 1'b0) begin failures++; $display("FAIL b2b_first got=%h/%b exp=01/0", bus.out_data, bus.mismatch); end
        tick();
        n++;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle in_ready=%b out_valid=%b exp=1,0", bus.in_ready, bus.out_valid); end
        tick();
        n++;
        checks++; if (bus.in_ready !== 1'b0 || n !== 14) begin failures++; $display("FAIL b2b_second_accept in_ready=%b period=%0d exp=0,14", bus.in_ready, n); end
        bus.in_valid = 1'b0;
        wait_valid(n);
        checks++; if (n !== 12) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=12", n); end
        checks++; if (bus.out_data !== 8'hFE || bus.mismatch !== 1'b0) begin failures++; $display("FAIL b2b_second got=%h/%b exp=fe/0", bus.out_data, bus.mismatch); end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        int n;
        bus.out_ready = 1'b1;
        accept(8'hFF, ok);
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || sr_din !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_during out_valid=%b sr_din=%b in_ready=%b exp=0,0,0", bus.out_valid, sr_din, bus.in_ready); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL midrst_out_data got=%h exp=00", bus.out_data); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || sr_din !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_after out_valid=%b sr_din=%b in_ready=%b exp=0,0,1", bus.out_valid, sr_din, bus.in_ready); end
        @(posedge clk);
        #1;
        accept(8'h81, ok);
        wait_valid(n);
        checks++; if (n !== 12) begin failures++; $display("FAIL midrst_latency got=%0d exp=12", n); end
        checks++; if (bus.out_data !== 8'h81 || bus.mismatch !== 1'b0) begin failures++; $display("FAIL midrst_result got=%h/%b exp=81/0", bus.out_data, bus.mismatch); end
        tick();
    endtask

    task automatic test_broken_loop();
        bit ok;
        int n;
        bus.out_ready = 1'b1;
        break_loop = 1'b1;
        accept(8'h5A, ok);
        wait_valid(n);
        checks++; if (n !== 12) begin failures++; $display("FAIL broken_latency got=%0d exp=12", n); end
        checks++; if (bus.out_data !== 8'h00 || bus.mismatch !== 1'b1) begin failures++; $display("FAIL broken_result got=%h/%b exp=00/1", bus.out_data, bus.mismatch); end
        tick();
        break_loop = 1'b0;
    endtask

    task automatic test_bit_order();
        bit ok;
        int n;
        logic [7:0] seq;
        logic [7:0] exp_seq;
`ifdef SHIFT_LOOP_LSB_FIRST_EN
        exp_seq = 8'b0000_0001;
`else
        exp_seq = 8'b1000_0000;
`endif
        bus.out_ready = 1'b1;
        seq = '0;
        accept(8'h01, ok);
        for (int k = 0; k < WIDTH; k++) begin
            seq[k] = sr_din;
            tick();
        end
        checks++; if (seq !== exp_seq) begin failures++; $display("FAIL order_sr_din got=%b exp=%b (bit k = cycle k)", seq, exp_seq); end
        wait_valid(n);
        checks++; if (n !== DEPTH) begin failures++; $display("FAIL order_latency got=%0d exp=%0d", n, DEPTH); end
        checks++; if (bus.out_data !== 8'h01 || bus.mismatch !== 1'b0) begin failures++; $display("FAIL order_result got=%h/%b exp=01/0", bus.out_data, bus.mismatch); end
        tick();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid_busy();
        test_broken_loop();
        test_bit_order();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_loop_ctrl.md
Name: shift_loop_ctrl

Overview:
Sequencer for the N-stage serial shift register (shiftReg, Din/clk/Dout, no enable, no reset). It accepts a parallel word over a valid/ready handshake, drives it bit-serially onto the register's Din, and recaptures the bits arriving at Dout DEPTH cycles later. It returns the recaptured word, plus a mismatch flag, over a second valid/ready handshake. It sits between a requester and the shift register and serves as loopback/self-check and as the register's sole controller.

Parameters:
WIDTH, 8, bits per word serialized
DEPTH, 4, flop stages of the attached shift register (must equal its N); ≥1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request word valid
in_ready  output  1  controller can accept a word
in_data  input  WIDTH  word to serialize
sr_din  output  1  drives shift register Din
sr_dout  input  1  from shift register Dout
out_valid  output  1  recaptured word available
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  recaptured word
mismatch  output  1  out_data != accepted in_data; valid with out_valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, in_ready=0 during reset then 1 in IDLE, sr_din=0, out_valid=0, out_data=0, mismatch=0, latched word=0.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1, sr_din=0. in_valid&in_ready at edge -> latch in_data into word, cnt<=0, go BUSY.
- BUSY: in_ready=0. cnt runs 0..WIDTH+DEPTH-1, incrementing each cycle.
  - sr_din (combinational from cnt/word): word[WIDTH-1-cnt] while cnt<WIDTH (MSB first); 0 for cnt≥WIDTH (flush fill).
  - Capture: at the edge ending cycle cnt=c with DEPTH ≤ c ≤ DEPTH+WIDTH-1, sample sr_dout into capture bit WIDTH-1-(c-DEPTH).
  - At the edge ending cnt=WIDTH+DEPTH-1: go DONE; register out_data=captured word; mismatch=(captured != word).
- BUSY length is exactly WIDTH+DEPTH cycles. out_valid rises on the following cycle. Handshake-to-result latency is WIDTH+DEPTH+1 edges.
- DONE: out_valid=1, in_ready=0, sr_din=0. out_data and mismatch are held stable until out_valid&out_ready. On that edge go IDLE and clear out_valid; out_data holds its last value.
- Back-to-back: a new word can be accepted at the earliest on the first IDLE cycle after the DONE handshake, so the minimum period is WIDTH+DEPTH+2 cycles. in_valid during BUSY or DONE is ignored (not accepted, not queued).
- in_data changes after acceptance have no effect; the latched word is used.
- Stale shift-register contents from a previous word or power-up are never captured; the capture window starts only at cnt=DEPTH.
- Reset mid-BUSY/DONE: immediate return to the reset values; in-flight word discarded; no out_valid.
- cnt width is clog2(WIDTH+DEPTH); no wrap occurs within BUSY.

Optional Feature:
Macro SHIFT_LOOP_LSB_FIRST_EN.
- Defined: serialization is LSB first. sr_din=word[cnt] for cnt<WIDTH. The capture at cycle c fills bit c-DEPTH. out_data still equals in_data when the loop is intact.
- Undefined: MSB first, as in Behaviour.
- Timing, states and handshakes are identical in both builds.

Test Plan:
- WIDTH=8, DEPTH=4, shift register attached, in_data=8'hA5, out_ready=1 -> sr_din in BUSY cycles 0..7 = 1,0,1,0,0,1,0,1, then 0 for cycles 8..11; out_valid rises 13 edges after acceptance; out_data=8'hA5, mismatch=0.
- Same setup, out_ready=0 for 5 cycles after out_valid -> out_valid, out_data=8'hA5 and in_ready=0 held for all 5 cycles; in_valid with 8'h3C during the stall is not accepted; release -> IDLE next cycle.
- Back-to-back 8'h01 then 8'hFE with in_valid held high -> second acceptance exactly on the first IDLE cycle after the DONE handshake; results 8'h01 and 8'hFE in order, mismatch=0 both.
- sr_dout forced 0 (broken loop), in_data=8'h5A -> out_data=8'h00, mismatch=1.
- rst_n pulsed low at BUSY cycle 6 of 8'hFF -> out_valid=0, sr_din=0, in_ready=1 after release; the next word 8'h81 returns 8'h81, mismatch=0 despite stale register contents.
- With SHIFT_LOOP_LSB_FIRST_EN defined, in_data=8'h01 -> sr_din cycles 0..7 = 1,0,0,0,0,0,0,0; out_data=8'h01, mismatch=0. Without the macro -> sr_din = 0,0,0,0,0,0,0,1.
